// File: rtl/ps2_key_encoder.sv
// rtl/ps2_key_encoder.sv - key level bank to ps2_key press/release event encoder
// Optional round-robin selection: define PS2_KEY_ENCODER_RR_EN.
module ps2_key_encoder #(
    parameter int NUM_KEYS = 16,
    parameter int GAP      = 4,
    parameter logic [NUM_KEYS*9-1:0] CODES = {
        9'h034, 9'h023, 9'h02B, 9'h02D, 9'h01B, 9'h01C, 9'h036, 9'h02E,
        9'h01E, 9'h016, 9'h011, 9'h014, 9'h174, 9'h16B, 9'h172, 9'h175
    }
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [10:0]         ps2_key,
    output logic                event_stb,
    output logic                busy
);

    localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_GAP} state_t;

    state_t                state;
    state_t                state_next;
    logic [NUM_KEYS-1:0]   keys_m;
    logic [NUM_KEYS-1:0]   keys_s;
    logic [NUM_KEYS-1:0]   reported;
    logic [NUM_KEYS-1:0]   pending;
    logic [NUM_KEYS-1:0]   hi_mask;
    logic [NUM_KEYS-1:0]   search;
    logic [7:0]            cnt;
    logic [IW-1:0]         sel_q;
    logic                  lvl_q;
    logic [8:0]            entry_q;
    logic [IW-1:0]         sel_idx;
    logic                  sel_lvl;
    logic [8:0]            sel_entry;
    int                    start_i;

    assign pending = keys_s ^ reported;
    assign busy    = (state != S_IDLE);

`ifdef PS2_KEY_ENCODER_RR_EN
    logic [IW-1:0] last_q;

    assign start_i = (int'(last_q) == NUM_KEYS - 1) ? 0 : int'(last_q) + 1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= IW'(NUM_KEYS - 1);
        end else if (state == S_EMIT) begin
            last_q <= sel_q;
        end
    end
`else
    assign start_i = 0;
`endif

    // Search from start_i upward first; fall back to the whole vector to wrap around.
    always_comb begin
        hi_mask   = '0;
        sel_idx   = '0;
        sel_lvl   = 1'b0;
        sel_entry = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            hi_mask[i] = (i >= start_i);
        end
        search = ((pending & hi_mask) != '0) ? (pending & hi_mask) : pending;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (search[i]) begin
                sel_idx   = IW'(i);
                sel_lvl   = keys_s[i];
                sel_entry = CODES[9*i +: 9];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (enable && (pending != '0)) state_next = S_EMIT;
            S_EMIT:  state_next = S_GAP;
            S_GAP:   if (cnt == 8'd0) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            keys_m    <= '0;
            keys_s    <= '0;
            reported  <= '0;
            ps2_key   <= '0;
            event_stb <= 1'b0;
            cnt       <= '0;
            sel_q     <= '0;
            lvl_q     <= 1'b0;
            entry_q   <= '0;
        end else begin
            keys_m    <= keys;
            keys_s    <= keys_m;
            event_stb <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable && (pending != '0)) begin
                        sel_q   <= sel_idx;
                        lvl_q   <= sel_lvl;
                        entry_q <= sel_entry;
                    end
                end
                S_EMIT: begin
                    // The captured level is reported, so a later change re-pends the key.
                    ps2_key         <= {~ps2_key[10], lvl_q, entry_q};
                    reported[sel_q] <= lvl_q;
                    event_stb       <= 1'b1;
                    cnt             <= 8'(GAP - 1);
                end
                S_GAP: begin
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
